// File: rtl/hook_pkg.sv
// Shared definitions for the hook motion controller and the hook renderer:
// state encoding, datapath widths and default motion bounds.
package hook_pkg;

   localparam int DEG_W   = 9;
   localparam int LEN_W   = 10;
   localparam int ARITH_W = 11;   // wide enough that saturation never sees a wrap

   localparam int DEG_MIN         = 20;
   localparam int DEG_MAX         = 160;
   localparam int DEG_STEP        = 2;
   localparam int LEN_MIN         = 10;
   localparam int LEN_MAX         = 255;
   localparam int EXT_STEP        = 4;
   localparam int RET_STEP        = 4;
   localparam int RET_STEP_LOADED = 1;

   typedef enum logic [1:0] {
      S_SWING   = 2'b00,
      S_EXTEND  = 2'b01,
      S_RETRACT = 2'b10
   } state_e;

   // Loaded retract step for a weighted item: heavier items reel in slower, never stall.
   function automatic logic [ARITH_W-1:0] weighted_step(input logic [1:0] w);
      logic [ARITH_W-1:0] s;
      s = ARITH_W'(RET_STEP) >> w;
      return (s == '0) ? ARITH_W'(1) : s;
   endfunction

endpackage

// File: rtl/hook_motion_ctrl_if.sv
// Bus between the frame/launch source (master) and hook_motion_ctrl (slave).
// The weight input only exists when HOOK_WEIGHT_EN is defined.
interface hook_motion_ctrl_if;
   import hook_pkg::*;

   logic             tick;
   logic             fire;
   logic             grab;
   logic             draw_done;
`ifdef HOOK_WEIGHT_EN
   logic [1:0]       weight;
`endif
   logic [DEG_W-1:0] degree;
   logic [LEN_W-1:0] length;
   logic             draw_start;
   logic             busy;
   state_e           state;
   logic             loaded;
   logic             caught;
   logic             frame_miss;

   modport master (
`ifdef HOOK_WEIGHT_EN
      output weight,
`endif
      output tick, fire, grab, draw_done,
      input  degree, length, draw_start, busy, state, loaded, caught, frame_miss
   );

   modport slave (
`ifdef HOOK_WEIGHT_EN
      input  weight,
`endif
      input  tick, fire, grab, draw_done,
      output degree, length, draw_start, busy, state, loaded, caught, frame_miss
   );

endinterface

// File: rtl/hook_sat_step.sv
// Combinational saturating step: moves val_i by step_i up or down and clamps
// to [lo_i, hi_i]. hit_o flags that the result landed on the bound.
module hook_sat_step
   import hook_pkg::*;
(
   input  logic [ARITH_W-1:0] val_i,
   input  logic [ARITH_W-1:0] step_i,
   input  logic [ARITH_W-1:0] lo_i,
   input  logic [ARITH_W-1:0] hi_i,
   input  logic               up_i,
   output logic [ARITH_W-1:0] res_o,
   output logic               hit_o
);

   // Compare before subtracting so a small value never underflows.
   always_comb begin
      res_o = val_i;
      hit_o = 1'b0;
      if (up_i) begin
         if (val_i + step_i >= hi_i) begin
            res_o = hi_i;
            hit_o = 1'b1;
         end else begin
            res_o = val_i + step_i;
         end
      end else begin
         if (val_i <= lo_i + step_i) begin
            res_o = lo_i;
            hit_o = 1'b1;
         end else begin
            res_o = val_i - step_i;
         end
      end
   end

endmodule

// File: rtl/hook_motion_ctrl.sv
// Hook motion controller: per accepted frame tick advances swing angle or rope
// length, then launches one redraw and waits for draw_done.
// Optional build macro HOOK_WEIGHT_EN: item weight slows the loaded retract.
module hook_motion_ctrl
   import hook_pkg::*;
(
   input logic               clock,
   input logic               resetn,
   hook_motion_ctrl_if.slave bus
);

   state_e             state_q, state_d;
   logic [DEG_W-1:0]   degree_q, degree_d;
   logic [LEN_W-1:0]   length_q, length_d;
   logic               dir_q, dir_d;          // 1 = degree increasing
   logic               busy_q, busy_d;
   logic               draw_start_q, draw_start_d;
   logic               loaded_q, loaded_d;
   logic               caught_q, caught_d;
   logic               frame_miss_q, frame_miss_d;
   logic               fire_pend_q, fire_pend_d;
   logic [ARITH_W-1:0] lstep_q, lstep_d;      // retract step for a loaded hook

   logic               accept;
   logic [ARITH_W-1:0] deg_res, len_res, len_step;
   logic               deg_hit, len_hit;

   assign accept   = bus.tick && !busy_q;
   assign len_step = (state_q == S_EXTEND) ? ARITH_W'(EXT_STEP) :
                     loaded_q ? lstep_q : ARITH_W'(RET_STEP);

   hook_sat_step u_deg_step (
      .val_i (ARITH_W'(degree_q)),
      .step_i(ARITH_W'(DEG_STEP)),
      .lo_i  (ARITH_W'(DEG_MIN)),
      .hi_i  (ARITH_W'(DEG_MAX)),
      .up_i  (dir_q),
      .res_o (deg_res),
      .hit_o (deg_hit)
   );

   hook_sat_step u_len_step (
      .val_i (ARITH_W'(length_q)),
      .step_i(len_step),
      .lo_i  (ARITH_W'(LEN_MIN)),
      .hi_i  (ARITH_W'(LEN_MAX)),
      .up_i  (state_q == S_EXTEND),
      .res_o (len_res),
      .hit_o (len_hit)
   );

   // Next-state: draw handshake, dropped-tick detection and per-state motion.
   always_comb begin
      state_d      = state_q;
      degree_d     = degree_q;
      length_d     = length_q;
      dir_d        = dir_q;
      busy_d       = busy_q;
      loaded_d     = loaded_q;
      lstep_d      = lstep_q;
      draw_start_d = 1'b0;
      caught_d     = 1'b0;
      frame_miss_d = bus.tick && busy_q;
      fire_pend_d  = fire_pend_q || bus.fire;

      if (busy_q && bus.draw_done) busy_d = 1'b0;

      if (accept) begin
         busy_d       = 1'b1;
         draw_start_d = 1'b1;
         fire_pend_d  = 1'b0;
         unique case (state_q)
            S_SWING: begin
               if (fire_pend_q || bus.fire) begin
                  state_d = S_EXTEND;
               end else begin
                  degree_d = deg_res[DEG_W-1:0];
                  if (deg_hit) dir_d = !dir_q;
               end
            end
            S_EXTEND: begin
               if (bus.grab) begin
                  loaded_d = 1'b1;
                  state_d  = S_RETRACT;
`ifdef HOOK_WEIGHT_EN
                  lstep_d  = weighted_step(bus.weight);
`else
                  lstep_d  = ARITH_W'(RET_STEP_LOADED);
`endif
               end else begin
                  length_d = len_res[LEN_W-1:0];
                  if (len_hit) state_d = S_RETRACT;
               end
            end
            S_RETRACT: begin
               length_d = len_res[LEN_W-1:0];
               if (len_hit) begin
                  state_d  = S_SWING;
                  caught_d = loaded_q;
                  loaded_d = 1'b0;
               end
            end
            default: state_d = S_SWING;
         endcase
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_SWING;
         degree_q     <= DEG_W'(90);
         length_q     <= LEN_W'(LEN_MIN);
         dir_q        <= 1'b1;
         busy_q       <= 1'b0;
         draw_start_q <= 1'b0;
         loaded_q     <= 1'b0;
         caught_q     <= 1'b0;
         frame_miss_q <= 1'b0;
         fire_pend_q  <= 1'b0;
         lstep_q      <= ARITH_W'(RET_STEP_LOADED);
      end else begin
         state_q      <= state_d;
         degree_q     <= degree_d;
         length_q     <= length_d;
         dir_q        <= dir_d;
         busy_q       <= busy_d;
         draw_start_q <= draw_start_d;
         loaded_q     <= loaded_d;
         caught_q     <= caught_d;
         frame_miss_q <= frame_miss_d;
         fire_pend_q  <= fire_pend_d;
         lstep_q      <= lstep_d;
      end
   end

   assign bus.degree     = degree_q;
   assign bus.length     = length_q;
   assign bus.state      = state_q;
   assign bus.busy       = busy_q;
   assign bus.draw_start = draw_start_q;
   assign bus.loaded     = loaded_q;
   assign bus.caught     = caught_q;
   assign bus.frame_miss = frame_miss_q;

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Directed bench for hook_motion_ctrl; expected values are hand-derived.
module tb_hook_motion_ctrl;
   import hook_pkg::*;

   logic clock = 1'b0;
   logic resetn;
   int   n_chk = 0;
   int   n_err = 0;
   logic ds, cg;
   int   cg_sum;

   always #5 clock = ~clock;

   hook_motion_ctrl_if bus ();

   hook_motion_ctrl dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One accepted tick answered by draw_done; returns draw_start/caught seen
   // in the cycle after the tick.
   task automatic tick_once(input logic g, output logic ds_o, output logic cg_o);
      @(negedge clock);
      bus.tick = 1'b1; bus.grab = g;
      @(negedge clock);
      bus.tick = 1'b0; bus.grab = 1'b0;
      ds_o = bus.draw_start; cg_o = bus.caught;
      bus.draw_done = 1'b1;
      @(negedge clock);
      bus.draw_done = 1'b0;
   endtask

   task automatic fire_pulse();
      @(negedge clock); bus.fire = 1'b1;
      @(negedge clock); bus.fire = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock); resetn = 1'b0;
      @(negedge clock); resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      bus.tick = 0; bus.fire = 0; bus.grab = 0; bus.draw_done = 0;
`ifdef HOOK_WEIGHT_EN
      bus.weight = 2'd0;
`endif
      repeat (2) @(negedge clock);
      chk("rst_degree", bus.degree, 90);
      chk("rst_length", bus.length, 10);
      chk("rst_state", bus.state, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_draw_start", bus.draw_start, 0);
      chk("rst_loaded", bus.loaded, 0);
      chk("rst_caught", bus.caught, 0);
      chk("rst_frame_miss", bus.frame_miss, 0);
      resetn = 1'b1;

      // Swing up from 90.
      for (int i = 1; i <= 3; i++) begin
         tick_once(1'b0, ds, cg);
         chk("swing_ds", ds, 1);
         chk("swing_deg", bus.degree, 90 + 2 * i);
      end
      chk("busy_cleared", bus.busy, 0);
      for (int i = 0; i < 31; i++) tick_once(1'b0, ds, cg);
      chk("deg_158", bus.degree, 158);
      tick_once(1'b0, ds, cg);
      chk("deg_max", bus.degree, 160);
      tick_once(1'b0, ds, cg);
      chk("deg_reverse", bus.degree, 158);

      // Dropped ticks: while busy and in the draw_done cycle.
      @(negedge clock); bus.tick = 1'b1;
      @(negedge clock);
      chk("acc_ds", bus.draw_start, 1);
      chk("acc_deg", bus.degree, 156);
      @(negedge clock);
      chk("miss_busy", bus.frame_miss, 1);
      chk("miss_ds", bus.draw_start, 0);
      chk("miss_deg", bus.degree, 156);
      bus.draw_done = 1'b1;
      @(negedge clock);
      bus.tick = 1'b0; bus.draw_done = 1'b0;
      chk("miss_done_cycle", bus.frame_miss, 1);
      chk("miss_done_busy", bus.busy, 0);
      chk("miss_done_deg", bus.degree, 156);
      @(negedge clock);
      chk("miss_clear", bus.frame_miss, 0);

      // Fire: extend to LEN_MAX, retract empty to LEN_MIN.
      fire_pulse();
      chk("fire_still_swing", bus.state, 0);
      tick_once(1'b0, ds, cg);
      chk("ext_state", bus.state, 1);
      chk("ext_deg_frozen", bus.degree, 156);
      chk("ext_len0", bus.length, 10);
      tick_once(1'b0, ds, cg);
      chk("ext_len14", bus.length, 14);
      for (int i = 0; i < 60; i++) tick_once(1'b0, ds, cg);
      chk("ext_len254", bus.length, 254);
      tick_once(1'b0, ds, cg);
      chk("ext_len255", bus.length, 255);
      chk("ext_to_retract", bus.state, 2);
      tick_once(1'b0, ds, cg);
      chk("ret_len251", bus.length, 251);
      cg_sum = 0;
      for (int i = 0; i < 60; i++) begin
         tick_once(1'b0, ds, cg);
         cg_sum += int'(cg);
      end
      chk("ret_len11", bus.length, 11);
      tick_once(1'b0, ds, cg);
      cg_sum += int'(cg);
      chk("ret_len10", bus.length, 10);
      chk("ret_swing", bus.state, 0);
      chk("empty_no_caught", cg_sum, 0);
      chk("ret_deg", bus.degree, 156);

      // Grab at 50, loaded retract step 1.
      fire_pulse();
      tick_once(1'b0, ds, cg);
      for (int i = 0; i < 10; i++) tick_once(1'b0, ds, cg);
      chk("grab_len50", bus.length, 50);
      tick_once(1'b1, ds, cg);
      chk("grab_loaded", bus.loaded, 1);
      chk("grab_state", bus.state, 2);
      chk("grab_len_hold", bus.length, 50);
      tick_once(1'b0, ds, cg);
      chk("load_len49", bus.length, 49);
      cg_sum = 0;
      for (int i = 0; i < 38; i++) begin
         tick_once(1'b0, ds, cg);
         cg_sum += int'(cg);
      end
      chk("load_len11", bus.length, 11);
      chk("load_no_early_caught", cg_sum, 0);
      tick_once(1'b0, ds, cg);
      chk("caught_pulse", cg, 1);
      chk("caught_ds", ds, 1);
      chk("caught_swing", bus.state, 0);
      chk("caught_unload", bus.loaded, 0);
      chk("caught_len", bus.length, 10);

      // Reset mid-EXTEND at length 118.
      fire_pulse();
      tick_once(1'b0, ds, cg);
      for (int i = 0; i < 27; i++) tick_once(1'b0, ds, cg);
      chk("pre_rst_len", bus.length, 118);
      @(negedge clock); resetn = 1'b0; bus.tick = 1'b1;
      @(negedge clock); bus.tick = 1'b0;
      chk("mid_rst_state", bus.state, 0);
      chk("mid_rst_deg", bus.degree, 90);
      chk("mid_rst_len", bus.length, 10);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ds", bus.draw_start, 0);
      resetn = 1'b1;

`ifdef HOOK_WEIGHT_EN
      fire_pulse();
      tick_once(1'b0, ds, cg);
      tick_once(1'b0, ds, cg);
      bus.weight = 2'd2;
      tick_once(1'b1, ds, cg);
      tick_once(1'b0, ds, cg);
      chk("weight2_step", bus.length, 13);
      do_reset();
      fire_pulse();
      tick_once(1'b0, ds, cg);
      tick_once(1'b0, ds, cg);
      bus.weight = 2'd3;
      tick_once(1'b1, ds, cg);
      tick_once(1'b0, ds, cg);
      chk("weight3_step", bus.length, 13);
`else
      do_reset();
      chk("final_rst_len", bus.length, 10);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
